// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one backing RAM port between the icache line-fill
// path and the dcache fill / write-through path. One access in flight at a time;
// the dcache has priority but the icache cannot starve past STARVE_MAX grants.
module cache_mem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic         clk,
  input  logic         rstn,
  // icache
  input  logic         iIC_req,
  input  logic [31:0]  iIC_addr,
  output logic         oIC_ack,
  output logic [127:0] oIC_line,
  // dcache
  input  logic         iDC_req,
  input  logic         iDC_we,
  input  logic [31:0]  iDC_addr,
  input  logic [31:0]  iDC_wdata,
  output logic         oDC_ack,
  output logic [127:0] oDC_line,
  // RAM
  output logic         omem_req,
  output logic         omem_we,
  output logic [31:0]  omem_addr,
  output logic [31:0]  omem_wdata,
  input  logic         imem_ready,
  input  logic [127:0] imem_rdata,
  output logic         oerr
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;
  typedef enum logic {OWN_IC, OWN_DC} owner_e;

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  logic [31:0]   addr_q, addr_d;
  logic          we_q, we_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [127:0]  ic_line_q, ic_line_d;
  logic [127:0]  dc_line_q, dc_line_d;
  logic          err_q, err_d;
  logic          grant_dc, grant_ic;

  // Arbitration: dcache wins unless the waiting icache has hit its starve limit.
  always_comb begin
    grant_dc = iDC_req && !(iIC_req && (starve_q == SW'(STARVE_MAX)));
    grant_ic = iIC_req && !grant_dc;
  end

  // Next-state and datapath updates for the IDLE / BUSY / RESP sequence.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case statement leaves one unassigned, which would infer a latch.
    state_d   = state_q;
    owner_d   = owner_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    starve_d  = starve_q;
    tmo_d     = tmo_q;
    ic_line_d = ic_line_q;
    dc_line_d = dc_line_q;
    err_d     = err_q;

    unique case (state_q)
      IDLE: begin
        if (grant_dc) begin
          owner_d  = OWN_DC;
          addr_d   = iDC_we ? (iDC_addr & 32'hFFFF_FFFC) : (iDC_addr & 32'hFFFF_FFF0);
          we_d     = iDC_we;
          wdata_d  = iDC_wdata;
          starve_d = iIC_req ? (starve_q + SW'(1)) : '0;
          err_d    = 1'b0;
          state_d  = BUSY;
        end else if (grant_ic) begin
          owner_d  = OWN_IC;
          addr_d   = iIC_addr & 32'hFFFF_FFF0;
          we_d     = 1'b0;
          wdata_d  = '0;
          starve_d = '0;
          err_d    = 1'b0;
          state_d  = BUSY;
        end
      end

      BUSY: begin
        if (imem_ready) begin
          // Writes leave the line registers untouched.
          if (!we_q) begin
            if (owner_q == OWN_IC) ic_line_d = imem_rdata;
            else                   dc_line_d = imem_rdata;
          end
          state_d = RESP;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          // Give up on a dead RAM: return a zero line and flag the error.
          if (owner_q == OWN_IC) ic_line_d = '0;
          else                   dc_line_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      RESP: begin
        tmo_d   = '0;
        err_d   = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any access in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      owner_q   <= OWN_IC;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      starve_q  <= '0;
      tmo_q     <= '0;
      ic_line_q <= '0;
      dc_line_q <= '0;
      err_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q   <= state_d;
      owner_q   <= owner_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      starve_q  <= starve_d;
      tmo_q     <= tmo_d;
      ic_line_q <= ic_line_d;
      dc_line_q <= dc_line_d;
      err_q     <= err_d;
    end
  end

  // Outputs decode straight from registered state, so reset clears them at once.
  always_comb begin
    omem_req   = (state_q == BUSY);
    omem_we    = we_q;
    omem_addr  = addr_q;
    omem_wdata = wdata_q;
    oIC_ack    = (state_q == RESP) && (owner_q == OWN_IC);
    oDC_ack    = (state_q == RESP) && (owner_q == OWN_DC);
    oIC_line   = ic_line_q;
    oDC_line   = dc_line_q;
    oerr       = (state_q == RESP) && err_q;
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: a table of single accesses followed by
// hand-written sequences for starvation, timeout, reset and spurious ready.
module tb_cache_mem_arbiter;

  logic         clk = 1'b0;
  logic         rstn;
  logic         iIC_req, iDC_req, iDC_we, imem_ready;
  logic [31:0]  iIC_addr, iDC_addr, iDC_wdata;
  logic [127:0] imem_rdata;
  logic         oIC_ack, oDC_ack, omem_req, omem_we, oerr;
  logic [127:0] oIC_line, oDC_line;
  logic [31:0]  omem_addr, omem_wdata;

  int checks = 0;
  int errors = 0;

  cache_mem_arbiter #(.STARVE_MAX(4), .TIMEOUT(64)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .iIC_req    (iIC_req),
    .iIC_addr   (iIC_addr),
    .oIC_ack    (oIC_ack),
    .oIC_line   (oIC_line),
    .iDC_req    (iDC_req),
    .iDC_we     (iDC_we),
    .iDC_addr   (iDC_addr),
    .iDC_wdata  (iDC_wdata),
    .oDC_ack    (oDC_ack),
    .oDC_line   (oDC_line),
    .omem_req   (omem_req),
    .omem_we    (omem_we),
    .omem_addr  (omem_addr),
    .omem_wdata (omem_wdata),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .oerr       (oerr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Both acks must never be high together.
  always @(negedge clk) begin
    if (oIC_ack || oDC_ack) check("ack_excl", oIC_ack & oDC_ack, 1'b0);
  end

  // One complete access. Requests are already driven with the DUT in IDLE;
  // the next edge grants, the RAM answers after 'delay' extra BUSY cycles.
  task automatic access(input string tag, input logic exp_dc, input logic [31:0] exp_addr,
                        input logic exp_we, input logic [31:0] exp_wdata, input int delay,
                        input logic [127:0] rdata, input logic [127:0] exp_line);
    step();
    check({tag, ".req"},   omem_req,   1'b1);
    check({tag, ".addr"},  omem_addr,  exp_addr);
    check({tag, ".we"},    omem_we,    exp_we);
    check({tag, ".wdata"}, omem_wdata, exp_wdata);
    for (int d = 0; d < delay; d++) begin
      step();
      check({tag, ".busy_req"},  omem_req,  1'b1);
      check({tag, ".busy_addr"}, omem_addr, exp_addr);
      check({tag, ".busy_ack"},  oIC_ack | oDC_ack, 1'b0);
    end
    imem_rdata = rdata;
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    check({tag, ".ack"},      exp_dc ? oDC_ack : oIC_ack, 1'b1);
    check({tag, ".otherack"}, exp_dc ? oIC_ack : oDC_ack, 1'b0);
    check({tag, ".line"},     exp_dc ? oDC_line : oIC_line, exp_line);
    check({tag, ".err"},      oerr, 1'b0);
    check({tag, ".req_drop"}, omem_req, 1'b0);
    if (exp_dc) iDC_req = 1'b0;
    else        iIC_req = 1'b0;
    step();
    check({tag, ".ack_gone"}, oIC_ack | oDC_ack, 1'b0);
  endtask

  typedef struct {
    logic         ic;
    logic [31:0]  ic_addr;
    logic         dc;
    logic         dc_we;
    logic [31:0]  dc_addr;
    logic [31:0]  dc_wdata;
    int           delay;
    logic [127:0] rdata;
    logic         exp_dc;
    logic [31:0]  exp_addr;
    logic         exp_we;
    logic [31:0]  exp_wdata;
    logic [127:0] exp_line;
  } vec_t;

  localparam logic [127:0] LA = 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAA0001;
  localparam logic [127:0] LB = 128'hCAFEF00D_01234567_89ABCDEF_00C0FFEE;
  localparam logic [127:0] LC = 128'h0F0F0F0F_F0F0F0F0_13579BDF_2468ACE0;
  localparam logic [127:0] LD = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [127:0] LE = 128'h11112222_33334444_55556666_77778888;
  localparam logic [127:0] LF = 128'h99990000_AAAA1111_BBBB2222_CCCC3333;
  localparam logic [127:0] LG = 128'hDEAD0001_DEAD0002_DEAD0003_DEAD0004;
  localparam logic [127:0] LH = 128'h0000FFFF_1111EEEE_2222DDDD_3333CCCC;
  localparam logic [127:0] LI = 128'h87654321_0FEDCBA9_ABCDEF01_23456789;

  vec_t vecs[6];
  int   busy_n;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    iIC_req = 1'b0; iIC_addr = '0;
    iDC_req = 1'b0; iDC_we = 1'b0; iDC_addr = '0; iDC_wdata = '0;
    imem_ready = 1'b0; imem_rdata = '0;

    //            ic  ic_addr       dc  we  dc_addr       dc_wdata      dly rdata      exp_dc addr          we  wdata         line
    vecs[0] = '{1'b1, 32'h0000_1234, 1'b0, 1'b0, 32'h0,        32'h0,        3, LA,        1'b0, 32'h0000_1230, 1'b0, 32'h0,        LA};
    vecs[1] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0042, 32'hDEADBEEF, 0, {4{32'h11111111}}, 1'b1, 32'h0000_0040, 1'b1, 32'hDEADBEEF, 128'h0};
    vecs[2] = '{1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_2008, 32'h0000_0055, 1, LB,       1'b1, 32'h0000_2000, 1'b0, 32'h0000_0055, LB};
    vecs[3] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_2007, 32'h12345678, 2, {128{1'b1}}, 1'b1, 32'h0000_2004, 1'b1, 32'h12345678, LB};
    vecs[4] = '{1'b1, 32'h0000_4444, 1'b1, 1'b0, 32'h0000_300C, 32'h0,        0, LC,        1'b1, 32'h0000_3000, 1'b0, 32'h0,        LC};
    vecs[5] = '{1'b1, 32'h0000_4444, 1'b0, 1'b0, 32'h0,        32'h0,        2, LD,        1'b0, 32'h0000_4440, 1'b0, 32'h0,        LD};

    // Reset state.
    #12;
    check("rst.mem_req", omem_req, 1'b0);
    check("rst.mem_we", omem_we, 1'b0);
    check("rst.mem_addr", omem_addr, 32'h0);
    check("rst.mem_wdata", omem_wdata, 32'h0);
    check("rst.acks", {oIC_ack, oDC_ack, oerr}, 3'b000);
    check("rst.ic_line", oIC_line, 128'h0);
    check("rst.dc_line", oDC_line, 128'h0);
    step();
    rstn = 1'b1;
    step();

    // Table of single accesses.
    foreach (vecs[i]) begin
      iIC_req = vecs[i].ic;
      iIC_addr = vecs[i].ic_addr;
      iDC_req = vecs[i].dc;
      iDC_we = vecs[i].dc_we;
      iDC_addr = vecs[i].dc_addr;
      iDC_wdata = vecs[i].dc_wdata;
      access($sformatf("vec%0d", i), vecs[i].exp_dc, vecs[i].exp_addr, vecs[i].exp_we,
             vecs[i].exp_wdata, vecs[i].delay, vecs[i].rdata, vecs[i].exp_line);
    end

    // Starvation: icache waits while the dcache re-requests back to back.
    iIC_req = 1'b1; iIC_addr = 32'h0000_5000;
    iDC_we = 1'b0; iDC_addr = 32'h0000_6000; iDC_wdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      iDC_req = 1'b1;
      access($sformatf("starve%0d", i), (i < 4), (i < 4) ? 32'h0000_6000 : 32'h0000_5000,
             1'b0, 32'h0, 0, LE, LE);
    end
    // Counter cleared by the icache grant: dcache wins again.
    iIC_req = 1'b1;
    access("starve_clr", 1'b1, 32'h0000_6000, 1'b0, 32'h0, 0, LF, LF);
    iIC_req = 1'b0;

    // Timeout: RAM never answers.
    iIC_req = 1'b1; iIC_addr = 32'h0000_7010;
    step();
    busy_n = 0;
    while (omem_req && busy_n < 200) begin
      busy_n++;
      step();
    end
    check("tmo.busy_cycles", busy_n, 64);
    check("tmo.ic_ack", oIC_ack, 1'b1);
    check("tmo.err", oerr, 1'b1);
    check("tmo.line", oIC_line, 128'h0);
    iIC_req = 1'b0;
    step();
    check("tmo.err_gone", {oerr, oIC_ack}, 2'b00);
    iDC_req = 1'b1; iDC_we = 1'b0; iDC_addr = 32'h0000_7100;
    access("tmo.next", 1'b1, 32'h0000_7100, 1'b0, 32'h0, 1, LF, LF);

    // Reset during BUSY: request withdrawn immediately, no ack, re-granted later.
    iDC_req = 1'b1; iDC_we = 1'b0; iDC_addr = 32'h0000_8004;
    step();
    check("rstbusy.req", omem_req, 1'b1);
    step();
    #2 rstn = 1'b0;
    #1;
    check("rstbusy.req_drop", omem_req, 1'b0);
    check("rstbusy.dc_line", oDC_line, 128'h0);
    step();
    check("rstbusy.no_ack", oIC_ack | oDC_ack, 1'b0);
    rstn = 1'b1;
    access("rstbusy.regrant", 1'b1, 32'h0000_8000, 1'b0, 32'h0, 0, LG, LG);

    // Spurious ready in IDLE, then a dcache request raised during RESP.
    imem_ready = 1'b1; imem_rdata = LI;
    step();
    step();
    check("spur.req", omem_req, 1'b0);
    check("spur.acks", {oIC_ack, oDC_ack, oerr}, 3'b000);
    imem_ready = 1'b0;
    iIC_req = 1'b1; iIC_addr = 32'h0000_9000;
    step();
    check("spur.ic_addr", omem_addr, 32'h0000_9000);
    imem_rdata = LH; imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    check("spur.ic_ack", oIC_ack, 1'b1);
    check("spur.ic_line", oIC_line, LH);
    iIC_req = 1'b0;
    iDC_req = 1'b1; iDC_we = 1'b0; iDC_addr = 32'h0000_9100;
    step();
    check("spur.no_grant_in_resp", omem_req, 1'b0);
    access("spur.dc", 1'b1, 32'h0000_9100, 1'b0, 32'h0, 0, LI, LI);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
Shares the single backing RAM port between the instruction cache and the data cache miss/write paths. Accepts one request at a time from either cache and drives the RAM handshake. Returns a 128-bit line for reads or completes a write-through word store. Pulses a per-requester ack when the access is done. Sits between the fetch/memory stages' caches and the RAM model.

Parameters:
STARVE_MAX, 4, consecutive data-cache grants allowed while an icache request waits; the icache is granted after this many.
TIMEOUT, 64, cycles in a RAM access without imem_ready before the access is aborted with an error.

Ports:
clk  input  1  clock, rising edge
rstn  input  1  asynchronous active-low reset
iIC_req  input  1  icache line-fill request; held until oIC_ack
iIC_addr  input  32  icache miss address (line aligned by the arbiter: [3:0] forced to 0)
oIC_ack  output  1  one-cycle completion pulse to the icache
oIC_line  output  128  fill data; valid while oIC_ack=1
iDC_req  input  1  dcache request; held until oDC_ack
iDC_we  input  1  1 = word write-through, 0 = line fill
iDC_addr  input  32  dcache address (fills line aligned; writes word aligned: [1:0] forced to 0)
iDC_wdata  input  32  store data
oDC_ack  output  1  one-cycle completion pulse to the dcache
oDC_line  output  128  fill data; valid while oDC_ack=1
omem_req  output  1  RAM request; held until imem_ready
omem_we  output  1  RAM write enable
omem_addr  output  32  RAM address
omem_wdata  output  32  RAM write word
imem_ready  input  1  RAM done; read data valid the same cycle
imem_rdata  input  128  RAM line data
oerr  output  1  one-cycle pulse alongside the ack of a timed-out access

Behaviour:
- Reset values: all outputs 0; state IDLE; starve counter 0; timeout counter 0; line registers 0.
- States: IDLE, BUSY, RESP.
- IDLE, no request: stay in IDLE.
- IDLE, only one request pending: grant it.
- IDLE, both pending: grant the dcache, unless starve_cnt == STARVE_MAX, in which case grant the icache.
- Starve counter:
  - increments on a dcache grant while iIC_req=1;
  - clears on any icache grant;
  - clears on a dcache grant while iIC_req=0.
- On grant, register the owner, address, we and wdata. Go to BUSY with omem_req=1 from the next cycle.
- BUSY:
  - omem_req/we/addr/wdata stay stable;
  - on the first cycle with imem_ready=1, capture imem_rdata (reads only) into the owner's line register, drop omem_req and go to RESP;
  - the timeout counter increments each BUSY cycle without imem_ready.
- Timeout: when the timeout counter reaches TIMEOUT-1 with imem_ready still 0:
  - drop omem_req and go to RESP;
  - the line register is zeroed;
  - oerr=1 during RESP.
- RESP:
  - the owner's ack=1 for exactly one cycle, then IDLE;
  - the timeout counter clears.
  - Requesters drop req at the edge that ends RESP, so IDLE never re-grants a completed request.
- Write accesses leave the dcache line register unchanged. oDC_ack still pulses.
- Latency: request seen at cycle 0 → omem_req at cycle 1 → ready at cycle k≥1 → ack at cycle k+1. Minimum request-to-ack is 2 cycles.
- Requests arriving during BUSY/RESP are held by the requester and arbitrated at the next IDLE. At most one RAM access is ever outstanding.
- imem_ready outside BUSY is ignored.
- Mid-operation reset: the state machine returns to IDLE, omem_req drops asynchronously and the access is abandoned (no ack). The RAM must tolerate a withdrawn request.
- oIC_ack and oDC_ack are never high in the same cycle.

Test Plan:
- Icache fill only: addr 0x0000_1234, RAM ready 3 cycles after omem_req with rdata 0xAAAA…_0001 → omem_addr 0x0000_1230, we=0; oIC_ack one cycle later with that line; oerr=0.
- Dcache write 0x0000_0042 ← 0xDEADBEEF, ready on the first BUSY cycle → omem_we=1, omem_addr 0x40, wdata 0xDEADBEEF; oDC_ack 2 cycles after the request; oDC_line unchanged.
- Simultaneous requests, dcache re-requesting back-to-back, STARVE_MAX=4 → four dcache grants, then the icache grant on the fifth arbitration; the counter then clears.
- RAM never asserts ready, TIMEOUT=64 → omem_req drops after 64 BUSY cycles; the owner's ack and oerr pulse together; line=0; the next request proceeds normally.
- rstn pulled low during BUSY → omem_req=0 immediately; no ack; after release, a pending request is re-granted from IDLE.
- Spurious imem_ready in IDLE, plus a request raised during RESP → no state change from the ready; the new request is granted only after returning to IDLE.
